// File: rtl/alu_param.sv
// Parametrised ALU with registered result, Z/C flags and a START/DONE handshake.
// Define ALU_SHIFT_EN to build the multi-cycle serial SHL/SHR path; otherwise OP 4/5 are reserved.
module alu_param #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [WIDTH-1:0] IM,
  input  logic [1:0]       SEL,
  input  logic [2:0]       OP,
  input  logic             START,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] STOREDATA,
  output logic             Z_FLAG,
  output logic             C_FLAG
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   sum;
  logic             accept;

  logic [WIDTH-1:0] data_q, data_d;
  logic             z_q, z_d;
  logic             c_q, c_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  assign m      = SEL[0] ? Y : IM;
  assign b      = m ^ {WIDTH{SEL[1]}};
  assign sum    = {1'b0, X} + {1'b0, b} + {{WIDTH{1'b0}}, SEL[1]};
  assign accept = START && !busy_q;

`ifdef ALU_SHIFT_EN
  typedef enum logic {S_IDLE, S_SHIFT} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    n_amt;
  logic             dir_q, dir_d;
  logic             out_bit;

  // Shift distance saturates at WIDTH; anything larger clears the word anyway.
  assign n_amt   = (32'(m) >= WIDTH) ? CW'(WIDTH) : CW'(m);
  assign shifted = dir_q ? (work_q >> 1) : (work_q << 1);
  assign out_bit = dir_q ? work_q[0] : work_q[WIDTH-1];
`endif

  always_comb begin
    data_d = data_q;
    z_d    = z_q;
    c_d    = c_q;
    done_d = 1'b0;
    busy_d = busy_q;
`ifdef ALU_SHIFT_EN
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
`endif
    if (accept) begin
      done_d = 1'b1;
      case (OP)
        3'd0: begin
          data_d = sum[WIDTH-1:0];
          c_d    = sum[WIDTH];
          z_d    = (sum[WIDTH-1:0] == '0);
        end
        3'd1: data_d = X & b;
        3'd2: data_d = X | b;
        3'd3: data_d = X ^ b;
`ifdef ALU_SHIFT_EN
        3'd4, 3'd5: begin
          if (n_amt == '0) begin
            data_d = X;
            z_d    = (X == '0);
          end else begin
            done_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = S_SHIFT;
            work_d  = X;
            cnt_d   = n_amt;
            dir_d   = OP[0];
          end
        end
`endif
        default: ;
      endcase
    end
`ifdef ALU_SHIFT_EN
    // The working register is private; STOREDATA only sees the final value.
    if (state_q == S_SHIFT) begin
      work_d = shifted;
      cnt_d  = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        data_d  = shifted;
        c_d     = out_bit;
        z_d     = (shifted == '0);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_q <= '0;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
`ifdef ALU_SHIFT_EN
      state_q <= S_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
`endif
    end else begin
      data_q <= data_d;
      z_q    <= z_d;
      c_q    <= c_d;
      done_q <= done_d;
      busy_q <= busy_d;
`ifdef ALU_SHIFT_EN
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
`endif
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign STOREDATA = data_q;
  assign Z_FLAG    = z_q;
  assign C_FLAG    = c_q;
endmodule

// File: tb/tb_alu_param.sv
// Scoreboard bench for alu_param: a 4-bit and an 8-bit instance, directed vectors,
// expected results queued at issue time and checked by per-instance DONE monitors.
module tb_alu_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] x4, y4, im4, sd4;
  logic [1:0] sel4;
  logic [2:0] op4;
  logic       start4, busy4, done4, z4, c4;
  logic [7:0] x8, y8, im8, sd8;
  logic [1:0] sel8;
  logic [2:0] op8;
  logic       start8, busy8, done8, z8, c8;

  alu_param #(.WIDTH(4)) dut4 (
    .CLK(clk), .RST(rst), .X(x4), .Y(y4), .IM(im4), .SEL(sel4), .OP(op4),
    .START(start4), .BUSY(busy4), .DONE(done4), .STOREDATA(sd4),
    .Z_FLAG(z4), .C_FLAG(c4)
  );

  alu_param #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst), .X(x8), .Y(y8), .IM(im8), .SEL(sel8), .OP(op8),
    .START(start8), .BUSY(busy8), .DONE(done8), .STOREDATA(sd8),
    .Z_FLAG(z8), .C_FLAG(c8)
  );

  typedef struct {
    logic [15:0] data;
    logic        z;
    logic        c;
    int          cyc;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  exp_t e4, e8;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (rst && done4) begin
      $display("dut4 DONE @%0d data=%0h z=%0b c=%0b", cyc, sd4, z4, c4);
      if (q4.size() == 0) check("dut4_spurious_done", 16'(done4), 16'd0);
      else begin
        e4 = q4.pop_front();
        check("dut4_data", 16'(sd4), e4.data);
        check("dut4_z", 16'(z4), 16'(e4.z));
        check("dut4_c", 16'(c4), 16'(e4.c));
        check("dut4_done_cycle", 16'(cyc), 16'(e4.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (rst && done8) begin
      $display("dut8 DONE @%0d data=%0h z=%0b c=%0b", cyc, sd8, z8, c8);
      if (q8.size() == 0) check("dut8_spurious_done", 16'(done8), 16'd0);
      else begin
        e8 = q8.pop_front();
        check("dut8_data", 16'(sd8), e8.data);
        check("dut8_z", 16'(z8), 16'(e8.z));
        check("dut8_c", 16'(c8), 16'(e8.c));
        check("dut8_done_cycle", 16'(cyc), 16'(e8.cyc));
      end
    end
  end

  // Called on a falling edge; returns on the falling edge after the accepting edge.
  task automatic issue4(input logic [3:0] x, input logic [3:0] y, input logic [3:0] im,
                        input logic [1:0] sel, input logic [2:0] op,
                        input logic [3:0] ed, input logic ez, input logic ec,
                        input int lat, input bit expect_done);
    x4 = x; y4 = y; im4 = im; sel4 = sel; op4 = op; start4 = 1'b1;
    if (expect_done) q4.push_back('{data: 16'(ed), z: ez, c: ec, cyc: cyc + 1 + lat});
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] x, input logic [7:0] y, input logic [7:0] im,
                        input logic [1:0] sel, input logic [2:0] op,
                        input logic [7:0] ed, input logic ez, input logic ec);
    x8 = x; y8 = y; im8 = im; sel8 = sel; op8 = op; start8 = 1'b1;
    q8.push_back('{data: 16'(ed), z: ez, c: ec, cyc: cyc + 1});
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_idle4();
    for (int i = 0; i < 20 && busy4; i++) @(negedge clk);
    check("dut4_idle_timeout", 16'(busy4), 16'd0);
  endtask

  initial begin
    rst = 1'b0;
    x4 = '0; y4 = '0; im4 = '0; sel4 = '0; op4 = '0; start4 = 1'b0;
    x8 = '0; y8 = '0; im8 = '0; sel8 = '0; op8 = '0; start8 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_dut4", 16'({sd4, z4, c4, busy4, done4}), 16'd0);
    check("reset_dut8", 16'({sd8, z8, c8, busy8, done8}), 16'd0);
    rst = 1'b1;
    @(negedge clk);

    // Reset asserted after the first shift edge aborts the operation.
`ifdef ALU_SHIFT_EN
    issue4(4'b1011, 4'd3, 4'd0, 2'b01, 3'd4, 4'd0, 1'b0, 1'b0, 3, 1'b0);
`else
    issue4(4'b1011, 4'd3, 4'd0, 2'b01, 3'd4, 4'd0, 1'b0, 1'b0, 0, 1'b1);
`endif
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("abort_outputs", 16'({sd4, z4, c4, busy4, done4}), 16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    issue4(4'd5, 4'd0, 4'd2, 2'b00, 3'd0, 4'd7, 1'b0, 1'b0, 0, 1'b1);

    issue4(4'd3, 4'd3, 4'd0, 2'b11, 3'd0, 4'd0, 1'b1, 1'b1, 0, 1'b1);

    // SHL by 3 with a second START (and changed inputs) while busy.
`ifdef ALU_SHIFT_EN
    issue4(4'b1011, 4'd3, 4'd0, 2'b01, 3'd4, 4'b1000, 1'b0, 1'b1, 3, 1'b1);
    check("shl_busy_c1", 16'(busy4), 16'd1);
    x4 = 4'd1; y4 = 4'd1; sel4 = 2'b01; op4 = 3'd0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check("shl_busy_c2", 16'(busy4), 16'd1);
    @(negedge clk);
    check("shl_busy_c3", 16'(busy4), 16'd1);
    @(negedge clk);
    check("shl_busy_fall_with_done", 16'({busy4, done4}), 16'b01);
`else
    issue4(4'b1011, 4'd3, 4'd0, 2'b01, 3'd4, 4'd0, 1'b1, 1'b1, 0, 1'b1);
    check("shl_reserved_busy", 16'(busy4), 16'd0);
    issue4(4'd1, 4'd1, 4'd0, 2'b01, 3'd0, 4'd2, 1'b0, 1'b0, 0, 1'b1);
`endif
    wait_idle4();

    issue4(4'd1, 4'd0, 4'd1, 2'b00, 3'd0, 4'd2, 1'b0, 1'b0, 0, 1'b1);

    // SHR by IM=9 saturates to 4.
`ifdef ALU_SHIFT_EN
    issue4(4'b1001, 4'd0, 4'd9, 2'b00, 3'd5, 4'd0, 1'b1, 1'b1, 4, 1'b1);
    check("shr_sat_busy", 16'(busy4), 16'd1);
`else
    issue4(4'b1001, 4'd0, 4'd9, 2'b00, 3'd5, 4'd2, 1'b0, 1'b0, 0, 1'b1);
    check("shr_sat_busy", 16'(busy4), 16'd0);
`endif
    wait_idle4();

`ifdef ALU_SHIFT_EN
    issue4(4'd5, 4'd5, 4'd5, 2'b01, 3'd6, 4'd0, 1'b1, 1'b1, 0, 1'b1);
    issue4(4'b0101, 4'd0, 4'd0, 2'b00, 3'd4, 4'b0101, 1'b0, 1'b1, 0, 1'b1);
`else
    issue4(4'd5, 4'd5, 4'd5, 2'b01, 3'd6, 4'd2, 1'b0, 1'b0, 0, 1'b1);
    issue4(4'b0101, 4'd0, 4'd0, 2'b00, 3'd4, 4'd2, 1'b0, 1'b0, 0, 1'b1);
`endif
    check("shl_n0_busy", 16'(busy4), 16'd0);

    issue8(8'hF0, 8'h00, 8'h20, 2'b00, 3'd0, 8'h10, 1'b0, 1'b1);
    issue8(8'hAA, 8'hAA, 8'h00, 2'b01, 3'd3, 8'h00, 1'b0, 1'b1);

    repeat (6) @(negedge clk);
    check("q4_drained", 16'(q4.size()), 16'd0);
    check("q8_drained", 16'(q8.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
